// File: rtl/branch_resolve.sv
// branch_resolve
//   Consumer side of the branch comparator. Decodes the branch condition from
//   funct3 and the comparator flags, decides whether the execute-stage
//   instruction redirects fetch, owns the PC and the fetch valid/ready
//   handshake, pulses flush on every redirect and keeps saturating branch
//   statistics.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   instr_valid                 execute stage holds a valid instruction
//   is_branch/is_jal/is_jalr    decoded control-transfer type
//   funct3                      branch condition code
//   br_less, br_equal           comparator flags
//   target                      computed target address
//   fetch_ready                 instruction memory accepts the request
//   clr_cnt                     synchronous clear of the statistics counters
//   br_unsigned                 to comparator, funct3[1]
//   pc, pc_four                 fetch address and fetch address + 4
//   fetch_valid                 fetch request valid
//   flush                       one-cycle squash of the younger instruction
//   misalign_err                one-cycle pulse on a misaligned taken target
//   br_cnt, taken_cnt           resolved / taken conditional branch counts
module branch_resolve #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic             br_less,
    input  logic             br_equal,
    input  logic [31:0]      target,
    input  logic             fetch_ready,
    input  logic             clr_cnt,
    output logic             br_unsigned,
    output logic [31:0]      pc,
    output logic [31:0]      pc_four,
    output logic             fetch_valid,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] redir_addr;
    logic        active;
    logic        legal;
    logic        taken;
    logic        want;
    logic        redirect;
    logic        misaligned;
    logic        br_count;
    logic        tk_count;

    assign br_unsigned = funct3[1];
    assign pc_four     = pc + 32'd4;

    // During FLUSH the execute-stage instruction is the squashed one, so
    // only RUN/STALL may act on instr_valid.
    assign active = instr_valid && (state == RUN || state == STALL);

    // funct3 = 01x has no branch meaning: never taken, never counted.
    assign legal = (funct3[2:1] != 2'b01);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = br_equal;
            3'b001:         taken = !br_equal;
            3'b100, 3'b110: taken = br_less;
            3'b101, 3'b111: taken = !br_less;
            default:        taken = 1'b0;
        endcase
    end

    // jal > jalr > branch when several flags are raised together.
    always_comb begin
        redir_addr = target;
        if (!is_jal && is_jalr)
            redir_addr = {target[31:1], 1'b0};
    end

    assign want       = active && (is_jal || is_jalr || (is_branch && legal && taken));
    assign misaligned = want && redir_addr[1];
    assign redirect   = want && !redir_addr[1];

    // Counters follow is_branch regardless of a simultaneous jump flag.
    assign br_count = active && is_branch && legal;
    assign tk_count = br_count && taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            misalign_err <= misaligned;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN, STALL: begin
                fetch_valid = 1'b1;
                // A redirect wins over the handshake; it is the only way
                // pc moves while a request is pending and not accepted.
                if (redirect) begin
                    pc_nxt    = redir_addr;
                    state_nxt = FLUSH;
                end else if (fetch_ready) begin
                    pc_nxt    = pc_four;
                    state_nxt = RUN;
                end else begin
                    state_nxt = STALL;
                end
            end
            FLUSH: begin
                fetch_valid = 1'b1;
                flush       = 1'b1;
                if (fetch_ready) begin
                    pc_nxt    = pc_four;
                    state_nxt = RUN;
                end else begin
                    state_nxt = STALL;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (clr_cnt) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (br_count && br_cnt != CNT_MAX)
                br_cnt <= br_cnt + CNT_ONE;
            if (tk_count && taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer side of the branch comparator: takes the comparator's br_less/br_equal flags and the decoded control-transfer fields, and decides whether the current instruction redirects the PC.
- Drives br_unsigned back to the comparator.
- Owns the PC register and the fetch-request valid/ready handshake.
- Issues a one-cycle flush on every redirect and keeps saturating branch statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  execute stage holds a valid instruction this cycle.
- is_branch  in  1  conditional branch (B-type).
- is_jal  in  1  JAL.
- is_jalr  in  1  JALR.
- funct3  in  3  branch condition code.
- br_less  in  1  from comparator.
- br_equal  in  1  from comparator.
- target  in  32  computed target address (ALU result).
- fetch_ready  in  1  instruction memory accepts the request.
- clr_cnt  in  1  synchronous clear of the statistics counters.
- br_unsigned  out  1  to comparator; combinational, equals funct3[1].
- pc  out  32  current fetch address.
- pc_four  out  32  pc + 4, combinational, wraps modulo 2^32.
- fetch_valid  out  1  fetch request valid.
- flush  out  1  squash younger instruction; single-cycle pulse.
- misalign_err  out  1  one-cycle pulse on a misaligned taken target.
- br_cnt  out  CNT_W  resolved conditional branches.
- taken_cnt  out  CNT_W  taken conditional branches.

Behaviour:

Reset (async, any state):
- pc=RESET_PC, fetch_valid=0, flush=0, misalign_err=0, counters=0, state=BOOT.

States:
- BOOT: fetch_valid=0, flush=0. Next cycle goes to RUN unconditionally.
- RUN: fetch_valid=1.
  - fetch_ready=1 and no redirect -> pc<=pc+4, stay RUN.
  - fetch_ready=0 and no redirect -> pc holds, go STALL.
- STALL: fetch_valid=1, pc and fetch_valid held stable until fetch_ready=1, then pc<=pc+4 and go RUN.
- FLUSH: entered the cycle after a redirect. flush=1, fetch_valid=1 at the new pc. instr_valid is ignored, so no redirect and no counter update. Exits like RUN/STALL depending on fetch_ready.

Condition decode (only when is_branch):
- 000 BEQ: taken = br_equal.
- 001 BNE: taken = !br_equal.
- 100 BLT, 110 BLTU: taken = br_less.
- 101 BGE, 111 BGEU: taken = !br_less.
- 010 and 011: never taken and not counted.

Redirect:
- redirect = instr_valid & state∈{RUN,STALL} & ((is_branch & taken) | is_jal | is_jalr).
- Address is target; for JALR, bit0 is forced to 0.
- Redirect has priority over fetch_ready. pc<=address next cycle, state<=FLUSH.
- Redirect is the only case where pc may change while fetch_valid=1 and fetch_ready=0.

Misaligned target:
- Redirect address bit1=1 -> no redirect, misalign_err=1 for one cycle, pc follows the normal fetch rule.

Counters:
- br_cnt increments on is_branch & instr_valid in RUN/STALL with legal funct3.
- taken_cnt increments when that branch is taken, including a misaligned taken branch.
- Both saturate at 2^CNT_W-1.
- clr_cnt zeroes both and has priority over an increment in the same cycle.

Simultaneous flags:
- If more than one of is_branch/is_jal/is_jalr is high, the priority is jal > jalr > branch.
- Counters still follow is_branch.

Reset mid-operation: every register returns to its reset value immediately, including mid-STALL and mid-FLUSH. No residual flush pulse.

Test Plan:
- Reset release, fetch_ready=1 -> BOOT cycle with fetch_valid=0, then pc = 0, 4, 8 on consecutive cycles; pc_four = pc+4.
- BEQ, br_equal=1, target=0x100, pc=0x8 -> next cycle pc=0x100 and flush=1 for exactly one cycle; br_cnt=1, taken_cnt=1.
- BNE with br_equal=1, then BLTU with br_less=0 -> neither redirects, no flush; br_cnt=2, taken_cnt=0; br_unsigned=0 for BNE and 1 for BLTU.
- fetch_ready=0 for 3 cycles at pc=0x20 -> pc stays 0x20 and fetch_valid stays 1; on ready, pc=0x24. Then JALR target=0x201 during STALL -> pc=0x200 and flush pulses once.
- Taken BGE with target=0x102 -> misalign_err pulses once, no flush, pc advances by 4, taken_cnt increments. funct3=010 with is_branch -> no redirect, no count.
- Preload both counters to all-ones (CNT_W=4 build), then a taken branch -> both stay 15. clr_cnt asserted with a branch in the same cycle -> both 0. Assert rst during FLUSH -> pc=RESET_PC and flush=0 immediately.
